// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Rotates or shifts an N-bit operand by 0..N-1 positions through S = log2(N)
// registered stages. Stage k applies a 2^k-bit move when amount bit k is set,
// so every operand passes through all S stages. A new request can enter on
// every cycle. When the output holds a result that downstream has not taken,
// the whole pipeline holds.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset; clears every stage
//   in_valid   request present on A/B/MODE
//   in_ready   block accepts a request this cycle (!out_valid | out_ready)
//   A          operand, N bits
//   B          shift/rotate amount, S bits
//   MODE       00 rotate right, 01 rotate left, 10 logical SR, 11 arithmetic SR
//   out_valid  Y holds a completed result
//   out_ready  downstream accepts Y this cycle
//   Y          result, N bits
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         A,
  input  logic [$clog2(N)-1:0] B,
  input  logic [1:0]           MODE,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         Y
);

  localparam int S = $clog2(N);

  // Stage registers. Each stage carries the full amount and the mode, so the
  // later stages can pick up their own amount bit.
  logic [N-1:0] data_q  [S];
  logic [S-1:0] b_q     [S];
  logic [1:0]   mode_q  [S];
  logic         valid_q [S];

  // Next-state values for each stage register.
  logic [N-1:0] data_d  [S];
  logic [S-1:0] b_d     [S];
  logic [1:0]   mode_d  [S];
  logic         valid_d [S];

  // A single global enable: the pipeline moves whenever the output slot is
  // empty or is being drained this cycle.
  assign in_ready  = !valid_q[S-1] || out_ready;
  assign out_valid = valid_q[S-1];
  assign Y         = data_q[S-1];

  generate
    for (genvar gi = 0; gi < S; gi++) begin : gen_stage
      localparam int K = 1 << gi;

      logic [N-1:0] d_in;
      logic [S-1:0] b_in;
      logic [1:0]   m_in;
      logic         v_in;
      logic [N-1:0] moved;

      if (gi == 0) begin : gen_src_port
        assign d_in = A;
        assign b_in = B;
        assign m_in = MODE;
        assign v_in = in_valid;
      end else begin : gen_src_prev
        assign d_in = data_q[gi-1];
        assign b_in = b_q[gi-1];
        assign m_in = mode_q[gi-1];
        assign v_in = valid_q[gi-1];
      end

      // K is at most N/2, so every slice below is non-empty.
      always_comb begin
        moved = d_in;
        case (m_in)
          2'b00:   moved = {d_in[K-1:0], d_in[N-1:K]};
          2'b01:   moved = {d_in[N-K-1:0], d_in[N-1:N-K]};
          2'b10:   moved = {{K{1'b0}}, d_in[N-1:K]};
          default: moved = {{K{d_in[N-1]}}, d_in[N-1:K]};
        endcase
      end

      assign data_d[gi]  = b_in[gi] ? moved : d_in;
      assign b_d[gi]     = b_in;
      assign mode_d[gi]  = m_in;
      // An empty upstream slot loads as a bubble.
      assign valid_d[gi] = v_in;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        data_q[k]  <= '0;
        b_q[k]     <= '0;
        mode_q[k]  <= 2'b00;
        valid_q[k] <= 1'b0;
      end
    end else if (in_ready) begin
      for (int k = 0; k < S; k++) begin
        data_q[k]  <= data_d[k];
        b_q[k]     <= b_d[k];
        mode_q[k]  <= mode_d[k];
        valid_q[k] <= valid_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

  logic       clk;
  logic       rst;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, y;
  logic [2:0] b;
  logic [1:0] mode;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, y16;
  logic [3:0]  b16;
  logic [1:0]  mode16;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] q8  [$];
  logic [63:0] q16 [$];

  pipelined_barrel_shifter #(.N(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .MODE(mode),
    .out_valid(out_valid), .out_ready(out_ready), .Y(y)
  );

  pipelined_barrel_shifter #(.N(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .MODE(mode16),
    .out_valid(out_valid16), .out_ready(out_ready16), .Y(y16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [2:0] b;
    logic [1:0] mode;
    logic [7:0] y;
  } vec_t;

  localparam int NV = 17;
  vec_t tv [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [2:0] bv, input logic [1:0] mv);
    in_valid = v;
    a        = av;
    b        = bv;
    mode     = mv;
  endtask

  // Bit-by-bit reference: result bit i is taken from source bit i+b (or i-b).
  function automatic logic [63:0] model(input int n, input logic [63:0] av, input int bv,
                                        input logic [1:0] mv);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      case (mv)
        2'b00:   r[i] = av[(i + bv) % n];
        2'b01:   r[i] = av[(i - bv + n) % n];
        2'b10:   r[i] = (i + bv < n) ? av[i + bv] : 1'b0;
        default: r[i] = (i + bv < n) ? av[i + bv] : av[n-1];
      endcase
    end
    return r;
  endfunction

  // Called just before an edge: retire a transferred result, then record an
  // accepted request.
  task automatic sb_step();
    logic [63:0] e;
    if (out_valid && out_ready) begin
      if (q8.size() == 0) chk("rand8 spurious result", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        chk("rand8 Y", {56'd0, y}, e);
      end
    end
    if (in_valid && in_ready) q8.push_back(model(8, {56'd0, a}, int'(b), mode));
    if (out_valid16 && out_ready16) begin
      if (q16.size() == 0) chk("rand16 spurious result", 64'd1, 64'd0);
      else begin
        e = q16.pop_front();
        chk("rand16 Y", {48'd0, y16}, e);
      end
    end
    if (in_valid16 && in_ready16) q16.push_back(model(16, {48'd0, a16}, int'(b16), mode16));
  endtask

  initial begin
    tv[0]  = '{8'h0C, 3'd0, 2'b00, 8'h0C};
    tv[1]  = '{8'h0C, 3'd1, 2'b00, 8'h06};
    tv[2]  = '{8'h0C, 3'd2, 2'b00, 8'h03};
    tv[3]  = '{8'h0C, 3'd3, 2'b00, 8'h81};
    tv[4]  = '{8'h0C, 3'd4, 2'b00, 8'hC0};
    tv[5]  = '{8'h0C, 3'd5, 2'b00, 8'h60};
    tv[6]  = '{8'h0C, 3'd6, 2'b00, 8'h30};
    tv[7]  = '{8'h0C, 3'd7, 2'b00, 8'h18};
    tv[8]  = '{8'h90, 3'd3, 2'b01, 8'h84};
    tv[9]  = '{8'h90, 3'd3, 2'b10, 8'h12};
    tv[10] = '{8'h90, 3'd3, 2'b11, 8'hF2};
    tv[11] = '{8'h90, 3'd0, 2'b11, 8'h90};
    tv[12] = '{8'h7F, 3'd7, 2'b11, 8'h00};
    tv[13] = '{8'h80, 3'd7, 2'b11, 8'hFF};
    tv[14] = '{8'hFF, 3'd7, 2'b10, 8'h01};
    tv[15] = '{8'h81, 3'd1, 2'b01, 8'h03};
    tv[16] = '{8'hA5, 3'd4, 2'b01, 8'h5A};

    // Reset with a request held on the inputs: it must be ignored.
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'hFF, 3'd1, 2'b00);
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; mode16 = 2'b00;
    tick();
    tick();
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset Y", {56'd0, y}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid16", {63'd0, out_valid16}, 64'd0);
    rst = 1'b0;

    // Table: back-to-back, first request on the first edge after release.
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) drive(1'b1, tv[c].a, tv[c].b, tv[c].mode);
      else        drive(1'b0, 8'h00, 3'd0, 2'b00);
      tick();
      if (c >= 2) begin
        chk($sformatf("vec%0d out_valid", c - 2), {63'd0, out_valid}, 64'd1);
        chk($sformatf("vec%0d Y", c - 2), {56'd0, y}, {56'd0, tv[c-2].y});
      end else begin
        chk($sformatf("latency edge%0d out_valid", c), {63'd0, out_valid}, 64'd0);
      end
    end
    tick();
    chk("table drained out_valid", {63'd0, out_valid}, 64'd0);

    // Stall: three requests, downstream refuses for five cycles.
    out_ready = 1'b0;
    drive(1'b1, 8'h12, 3'd1, 2'b00); tick();
    drive(1'b1, 8'h80, 3'd2, 2'b11); tick();
    drive(1'b1, 8'h01, 3'd1, 2'b01); tick();
    drive(1'b1, 8'hEE, 3'd5, 2'b10); // must not get in while stalled
    chk("stall first out_valid", {63'd0, out_valid}, 64'd1);
    chk("stall first Y", {56'd0, y}, 64'h09);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d Y held", k), {56'd0, y}, 64'h09);
      chk($sformatf("stall%0d in_ready", k), {63'd0, in_ready}, 64'd0);
    end
    drive(1'b0, 8'h00, 3'd0, 2'b00);
    out_ready = 1'b1;
    #1;
    chk("stall release in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("stall r1 Y", {56'd0, y}, 64'hE0);
    chk("stall r1 out_valid", {63'd0, out_valid}, 64'd1);
    tick();
    chk("stall r2 Y", {56'd0, y}, 64'h02);
    tick();
    chk("stall empty out_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("stall no extra out_valid", {63'd0, out_valid}, 64'd0);

    // Reset while requests are in flight.
    drive(1'b1, 8'h55, 3'd1, 2'b00); tick();
    drive(1'b1, 8'hF0, 3'd4, 2'b10); tick();
    drive(1'b0, 8'h00, 3'd0, 2'b00); tick();
    chk("pre-reset Y", {56'd0, y}, 64'hAA);
    rst = 1'b1;
    #1;
    chk("async reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("async reset Y", {56'd0, y}, 64'd0);
    chk("async reset in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post-reset%0d out_valid", k), {63'd0, out_valid}, 64'd0);
    end
    drive(1'b1, 8'h3C, 3'd2, 2'b01); tick();
    drive(1'b0, 8'h00, 3'd0, 2'b00); tick();
    chk("post-reset early out_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("post-reset out_valid", {63'd0, out_valid}, 64'd1);
    chk("post-reset Y", {56'd0, y}, 64'hF0);
    tick();

    // Bubbles: in_valid 1,0,1,0.
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(1'b1, 8'h11, 3'd4, 2'b00);
        2:       drive(1'b1, 8'h40, 3'd6, 2'b10);
        default: drive(1'b0, 8'hAB, 3'd3, 2'b01);
      endcase
      tick();
      chk($sformatf("bubble edge%0d out_valid", c), {63'd0, out_valid},
          {63'd0, (c == 2 || c == 4)});
      if (c == 2) chk("bubble r0 Y", {56'd0, y}, 64'h11);
      if (c == 4) chk("bubble r1 Y", {56'd0, y}, 64'h01);
    end

    // Random traffic on both widths with random backpressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid    = 1'($urandom_range(0, 1));
      a           = 8'($urandom);
      b           = 3'($urandom);
      mode        = 2'($urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
      in_valid16  = 1'($urandom_range(0, 1));
      a16         = 16'($urandom);
      b16         = 4'($urandom);
      mode16      = 2'($urandom);
      out_ready16 = ($urandom_range(0, 9) < 6);
      #1;
      sb_step();
      tick();
    end
    in_valid = 1'b0; in_valid16 = 1'b0;
    out_ready = 1'b1; out_ready16 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      sb_step();
      tick();
    end
    chk("rand8 leftover results", 64'(q8.size()), 64'd0);
    chk("rand16 leftover results", 64'(q16.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
